// File: rtl/operand_bank_pkg.sv
// Shared types and defaults for the double-buffered operand bank.
// Bank lifecycle states and load-side addressing modes.
package operand_bank_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  localparam logic WR_AUTO     = 1'b0;
  localparam logic WR_EXPLICIT = 1'b1;

endpackage

// File: rtl/operand_bank_slot.sv
// One operand bank: DEPTH x DATA_W storage with clear and a
// saturating beat counter; the top decides when to write or clear.
module operand_bank_slot
  import operand_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    we,
  input  logic                    beat,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       data_in,
  output logic [DEPTH*DATA_W-1:0] data,
  output logic [ADDR_W:0]         count
);

  localparam logic [ADDR_W:0] SAT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  assign in_range = 32'(addr) < DEPTH;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[addr] <= data_in;
    end
  end

  // Counts accepted beats, including dropped out-of-range ones.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (beat && count != SAT) begin
      count <= count + 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign data[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/operand_bank_pingpong.sv
// Ping-pong operand bank: one bank fills serially while the other,
// already committed, is presented in parallel to the array edge.
module operand_bank_pingpong
  import operand_bank_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    wr_addr_mode,
  input  logic                    wr_last,
  output logic                    wr_oob,
  output logic                    rd_valid,
  input  logic                    rd_ack,
  output logic [DEPTH*DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]         rd_count
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  bank_state_t       state [2];
  logic              wsel;
  logic              rsel;
  logic              mode;
  logic              oob_q;
  logic [ADDR_W-1:0] ptr;

  logic              accept;
  logic              ack;
  logic              first;
  logic              eff_mode;
  logic              oob;
  logic              commit;
  logic [ADDR_W-1:0] tgt;

  logic [DEPTH*DATA_W-1:0] slot_data  [2];
  logic [ADDR_W:0]         slot_count [2];

  assign wr_ready = state[wsel] != FULL;
  assign rd_valid = state[rsel] == FULL;
  assign accept   = wr_valid & wr_ready;
  assign ack      = rd_ack & rd_valid;

  // Mode is taken live on the first beat, then held until commit.
  assign first    = state[wsel] == EMPTY;
  assign eff_mode = first ? wr_addr_mode : mode;
  assign tgt      = (eff_mode == WR_EXPLICIT) ? wr_addr : ptr;
  assign oob      = (eff_mode == WR_EXPLICIT)
                  && (32'(wr_addr) >= DEPTH);
  assign commit   = accept
                  & (wr_last
                  | (eff_mode == WR_AUTO && ptr == LAST_PTR));

  assign rd_data  = rd_valid ? slot_data[rsel]  : '0;
  assign rd_count = rd_valid ? slot_count[rsel] : '0;
  assign wr_oob   = oob_q;

  for (genvar b = 0; b < 2; b++) begin : g_slot
    localparam logic ID = 1'(b);

    operand_bank_slot #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear   (ack && rsel == ID),
      .we      (accept && !oob && wsel == ID),
      .beat    (accept && wsel == ID),
      .addr    (tgt),
      .data_in (wr_data),
      .data    (slot_data[b]),
      .count   (slot_count[b])
    );
  end

  // Accept only targets a non-FULL bank and ack only a FULL one,
  // so both may update different banks on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state[0] <= EMPTY;
      state[1] <= EMPTY;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      ptr      <= '0;
      mode     <= WR_AUTO;
      oob_q    <= 1'b0;
    end else begin
      oob_q <= accept & oob;
      if (ack) begin
        state[rsel] <= EMPTY;
        rsel        <= ~rsel;
      end
      if (accept) begin
        state[wsel] <= commit ? FULL : FILLING;
        if (first) begin
          mode <= wr_addr_mode;
        end
        if (commit) begin
          ptr  <= '0;
          wsel <= ~wsel;
        end else if (eff_mode == WR_AUTO) begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end

  a_split_banks: assert property (
    @(posedge clk) disable iff (reset)
    (wsel != rsel) |-> (state[rsel] == FULL)
  );

  a_full_stalls: assert property (
    @(posedge clk) disable iff (reset)
    (state[0] == FULL && state[1] == FULL) |-> !wr_ready
  );

endmodule
